addr_decoder_ws: RTL and testbench

Parametrised, registered successor to the per-game chip-select decoder: compares the 68000 word address against `NUM_WIN` runtime-configured mask/match windows, resolves overlaps by fixed priority, and drives one-hot registered chip selects. Per-window programmable wait states, an external ready handshake and unmapped-access bus-error timeout generate `cpu_dtack_n`/`cpu_berr_n`. Savestate override regions are decoded in the same cycle with priority over normal windows. Sits between the main CPU bus and all slave blocks (ROM, work RAM, screen, object, color, IO, sound, ROZ, C-chip).

---
 rtl/addr_decoder_ws_pkg.sv | 40 ++++
 rtl/addr_decoder_ws_if.sv | 26 ++
 rtl/addr_decoder_ws_win_match.sv | 19 +
 rtl/addr_decoder_ws.sv | 186 ++++++++++++++++++
 tb/tb_addr_decoder_ws.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_decoder_ws_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addr_decoder_ws_pkg
// Purpose  : Shared types and savestate region constants for addr_decoder_ws.
// Revision : 1.0 - initial release
// ============================================================================
package addr_decoder_ws_pkg;

    // Window fields are carried at a fixed maximum width; narrower fields are zero-extended.
    localparam int C_WIN_FW_MAX = 24;

    typedef struct packed {
        logic [C_WIN_FW_MAX-1:0] match;
        logic [C_WIN_FW_MAX-1:0] mask;
    } addr_win_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        ACK      = 3'd2,
        UNMAPPED = 3'd3,
        BERR     = 3'd4
    } dec_state_t;

    localparam logic [23:0] C_SS_RESET_MASK  = 24'hFFFFF0;
    localparam logic [23:0] C_SS_RESET_MATCH = 24'h000000;
    localparam logic [23:0] C_SS_VEC_MASK    = 24'hFFFFFD;
    localparam logic [23:0] C_SS_VEC_MATCH   = 24'h00007C;
    localparam logic [23:0] C_SS_SAVE_MASK   = 24'hFFFF00;
    localparam logic [23:0] C_SS_SAVE_MATCH  = 24'hFF0000;

    // Returns {save, vec, reset}; the three regions are disjoint.
    function automatic logic [2:0] ss_decode(input logic [23:0] addr);
        ss_decode = {((addr & C_SS_SAVE_MASK)  == C_SS_SAVE_MATCH),
                     ((addr & C_SS_VEC_MASK)   == C_SS_VEC_MATCH),
                     ((addr & C_SS_RESET_MASK) == C_SS_RESET_MATCH)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_decoder_ws_if.sv
`default_nettype none
// ============================================================================
// Module   : addr_decoder_ws_if
// Purpose  : 68000-side bus strobes, address and bus-cycle termination.
// Revision : 1.0 - initial release
// ============================================================================
interface addr_decoder_ws_if #(
    parameter int ADDR_W = 24
);
    logic              cpu_as_n;
    logic [1:0]        cpu_ds_n;
    logic [ADDR_W-1:0] cpu_word_addr;
    logic              cpu_dtack_n;
    logic              cpu_berr_n;

    modport master (
        output cpu_as_n, cpu_ds_n, cpu_word_addr,
        input  cpu_dtack_n, cpu_berr_n
    );

    modport slave (
        input  cpu_as_n, cpu_ds_n, cpu_word_addr,
        output cpu_dtack_n, cpu_berr_n
    );
endinterface
`default_nettype wire

// File: rtl/addr_decoder_ws_win_match.sv
`default_nettype none
// ============================================================================
// Module   : addr_win_match
// Purpose  : Combinational mask/match compare for a single decode window.
// Revision : 1.0 - initial release
// ============================================================================
module addr_win_match
    import addr_decoder_ws_pkg::*;
(
    input  wire logic                    en,
    input  wire logic [C_WIN_FW_MAX-1:0] addr_fld,
    input  wire addr_win_t               win,
    output logic                         hit
);

    assign hit = en && ((addr_fld & win.mask) == win.match);

endmodule
`default_nettype wire

// File: rtl/addr_decoder_ws.sv
`default_nettype none
// ============================================================================
// Module   : addr_decoder_ws
// Purpose  : Registered priority chip-select decoder with wait states,
//            ready handshake, unmapped bus-error timeout and savestate regions.
// Revision : 1.0 - initial release
// ============================================================================
module addr_decoder_ws
    import addr_decoder_ws_pkg::*;
#(
    parameter int NUM_WIN = 16,
    parameter int ADDR_W  = 24,
    parameter int SEL_HI  = 23,
    parameter int SEL_LO  = 16,
    parameter int WS_W    = 4,
    parameter int TIMEOUT = 255,
    localparam int FW     = SEL_HI - SEL_LO + 1,
    localparam int IW     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
)(
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    addr_decoder_ws_if.slave             bus,
    input  wire logic                    ss_override,
    input  wire logic [NUM_WIN-1:0]      cfg_en,
    input  wire logic [NUM_WIN*2*FW-1:0] cfg_match,
    input  wire logic [NUM_WIN*WS_W-1:0] cfg_ws,
    input  wire logic [NUM_WIN-1:0]      win_ready,
    output logic [NUM_WIN-1:0]           cs_n,
    output logic [IW-1:0]                hit_idx,
    output logic                         ss_reset_n,
    output logic                         ss_vec_n,
    output logic                         ss_save_n
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [C_WIN_FW_MAX-1:0] addr_fld;
    logic [NUM_WIN-1:0]      win_hit;
    logic                    any_hit;
    logic [IW-1:0]           hit_sel;
    logic [2:0]              ss_sel;
    logic                    access_valid;

    dec_state_t              state_q, state_d;
    logic [IW-1:0]           hit_idx_q, hit_idx_d;
    logic [2:0]              ss_sel_q, ss_sel_d;
    logic [WS_W-1:0]         wcnt_q, wcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [NUM_WIN-1:0]      cs_n_q, cs_n_d;
    logic [2:0]              ss_n_q, ss_n_d;
    logic                    dtack_n_q, dtack_n_d;
    logic                    berr_n_q, berr_n_d;

    assign addr_fld     = C_WIN_FW_MAX'(bus.cpu_word_addr[SEL_HI:SEL_LO]);
    assign access_valid = !bus.cpu_as_n && !(&bus.cpu_ds_n);
    assign ss_sel       = ss_override ? ss_decode(24'(bus.cpu_word_addr)) : 3'b000;

    generate
        for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
            addr_win_t win_cfg;
            assign win_cfg.match = C_WIN_FW_MAX'(cfg_match[i*2*FW+FW +: FW]);
            assign win_cfg.mask  = C_WIN_FW_MAX'(cfg_match[i*2*FW    +: FW]);

            addr_win_match u_match (
                .en       (cfg_en[i]),
                .addr_fld (addr_fld),
                .win      (win_cfg),
                .hit      (win_hit[i])
            );
        end
    endgenerate

    // Scan from the top so the lowest-index hit is the last assignment.
    always_comb begin
        any_hit = 1'b0;
        hit_sel = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                any_hit = 1'b1;
                hit_sel = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hit_idx_q <= '0;
            ss_sel_q  <= '0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            cs_n_q    <= '1;
            ss_n_q    <= 3'b111;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            hit_idx_q <= hit_idx_d;
            ss_sel_q  <= ss_sel_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            cs_n_q    <= cs_n_d;
            ss_n_q    <= ss_n_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hit_idx_d = hit_idx_q;
        ss_sel_d  = ss_sel_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            IDLE: begin
                if (access_valid) begin
                    if (|ss_sel) begin
                        ss_sel_d = ss_sel;
                        wcnt_d   = '0;
                        state_d  = WAIT;
                    end else if (any_hit) begin
                        ss_sel_d  = '0;
                        hit_idx_d = hit_sel;
                        wcnt_d    = cfg_ws[hit_sel*WS_W +: WS_W];
                        state_d   = WAIT;
                    end else begin
                        ss_sel_d = '0;
                        tcnt_d   = TW'(TIMEOUT - 1);
                        state_d  = UNMAPPED;
                    end
                end
            end
            WAIT: begin
                if (bus.cpu_as_n) begin
                    state_d = IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else if (win_ready[hit_idx_q] || (|ss_sel_q)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (bus.cpu_as_n) state_d = IDLE;
            end
            UNMAPPED: begin
                if (bus.cpu_as_n) begin
                    state_d = IDLE;
                end else if (tcnt_q == '0) begin
                    state_d = BERR;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            BERR: begin
                if (bus.cpu_as_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        cs_n_d    = '1;
        ss_n_d    = 3'b111;
        dtack_n_d = (state_d != ACK);
        berr_n_d  = (state_d != BERR);
        if (state_d == WAIT || state_d == ACK) begin
            if (|ss_sel_d) begin
                ss_n_d = ~ss_sel_d;
            end else begin
                cs_n_d[hit_idx_d] = 1'b0;
            end
        end
    end

    assign cs_n            = cs_n_q;
    assign hit_idx         = hit_idx_q;
    assign ss_reset_n      = ss_n_q[0];
    assign ss_vec_n        = ss_n_q[1];
    assign ss_save_n       = ss_n_q[2];
    assign bus.cpu_dtack_n = dtack_n_q;
    assign bus.cpu_berr_n  = berr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_decoder_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_decoder_ws
// Purpose  : Directed self-checking bench for addr_decoder_ws.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr_decoder_ws;

    localparam int NUM_WIN = 16;
    localparam int FW      = 8;
    localparam int WS_W    = 4;
    localparam int TIMEOUT = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    addr_decoder_ws_if #(.ADDR_W(24)) bus ();

    logic                    ss_override;
    logic [NUM_WIN-1:0]      cfg_en;
    logic [NUM_WIN*2*FW-1:0] cfg_match;
    logic [NUM_WIN*WS_W-1:0] cfg_ws;
    logic [NUM_WIN-1:0]      win_ready;
    logic [NUM_WIN-1:0]      cs_n;
    logic [3:0]              hit_idx;
    logic                    ss_reset_n, ss_vec_n, ss_save_n;

    int n_checks = 0;
    int n_errors = 0;

    addr_decoder_ws #(
        .NUM_WIN (NUM_WIN),
        .ADDR_W  (24),
        .SEL_HI  (23),
        .SEL_LO  (16),
        .WS_W    (WS_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .ss_override (ss_override),
        .cfg_en      (cfg_en),
        .cfg_match   (cfg_match),
        .cfg_ws      (cfg_ws),
        .win_ready   (win_ready),
        .cs_n        (cs_n),
        .hit_idx     (hit_idx),
        .ss_reset_n  (ss_reset_n),
        .ss_vec_n    (ss_vec_n),
        .ss_save_n   (ss_save_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_win(input int i, input logic en, input logic [7:0] match,
                           input logic [7:0] mask, input logic [3:0] ws);
        cfg_en[i]               = en;
        cfg_match[i*2*FW +: 16] = {match, mask};
        cfg_ws[i*WS_W +: WS_W]  = ws;
    endtask

    // Returns just after E0.
    task automatic begin_access(input logic [23:0] a);
        bus.cpu_word_addr = a;
        bus.cpu_as_n      = 1'b0;
        bus.cpu_ds_n      = 2'b00;
        @(posedge clk);
        #1;
    endtask

    // Edges after E0 until DTACK or BERR goes low (bounded).
    task automatic wait_resp(output int n);
        n = 0;
        while (bus.cpu_dtack_n === 1'b1 && bus.cpu_berr_n === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic end_access(input string tag);
        bus.cpu_as_n = 1'b1;
        bus.cpu_ds_n = 2'b11;
        @(posedge clk);
        #1;
        chk({tag, "_rel_cs"}, 32'(cs_n), 32'hFFFF);
        chk({tag, "_rel_dtack"}, 32'(bus.cpu_dtack_n), 32'h1);
        chk({tag, "_rel_berr"}, 32'(bus.cpu_berr_n), 32'h1);
        chk({tag, "_rel_ss"}, 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h7);
    endtask

    initial begin
        int  n;
        bit  early;
        bus.cpu_as_n      = 1'b1;
        bus.cpu_ds_n      = 2'b11;
        bus.cpu_word_addr = '0;
        ss_override       = 1'b0;
        cfg_en            = '0;
        cfg_match         = '0;
        cfg_ws            = '0;
        win_ready         = '1;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs_n), 32'hFFFF);
        chk("rst_idx", 32'(hit_idx), 32'h0);
        chk("rst_dtack", 32'(bus.cpu_dtack_n), 32'h1);
        chk("rst_berr", 32'(bus.cpu_berr_n), 32'h1);
        chk("rst_ss", 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h7);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        set_win(2, 1'b1, 8'h10, 8'hFF, 4'd0);
        set_win(1, 1'b1, 8'h20, 8'hFF, 4'd3);
        set_win(5, 1'b1, 8'h20, 8'hF0, 4'd0);
        set_win(3, 1'b1, 8'h30, 8'hFF, 4'd0);
        set_win(4, 1'b1, 8'h40, 8'hFF, 4'd5);

        // Basic zero-wait access on window 2
        begin_access(24'h100000);
        chk("w2_cs", 32'(cs_n), 32'hFFFB);
        chk("w2_idx", 32'(hit_idx), 32'h2);
        chk("w2_dtack_e0", 32'(bus.cpu_dtack_n), 32'h1);
        wait_resp(n);
        chk("w2_lat", 32'(n), 32'h1);
        @(posedge clk);
        #1;
        chk("w2_hold_dtack", 32'(bus.cpu_dtack_n), 32'h0);
        chk("w2_hold_cs", 32'(cs_n), 32'hFFFB);
        end_access("w2");

        // Strobes without a data strobe are not an access
        bus.cpu_word_addr = 24'h100000;
        bus.cpu_as_n      = 1'b0;
        bus.cpu_ds_n      = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("nods_cs", 32'(cs_n), 32'hFFFF);
        bus.cpu_as_n = 1'b1;
        @(posedge clk);
        #1;

        // Overlap: window 1 beats window 5, three wait states
        begin_access(24'h20ABCD);
        chk("ovl_cs", 32'(cs_n), 32'hFFFD);
        chk("ovl_idx", 32'(hit_idx), 32'h1);
        wait_resp(n);
        chk("ovl_lat", 32'(n), 32'h4);
        end_access("ovl");

        // Slave not ready for six edges
        win_ready[3] = 1'b0;
        begin_access(24'h300010);
        chk("rdy_idx", 32'(hit_idx), 32'h3);
        early = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.cpu_dtack_n !== 1'b1) early = 1'b1;
        end
        chk("rdy_no_early", 32'(early), 32'h0);
        win_ready[3] = 1'b1;
        wait_resp(n);
        chk("rdy_lat_total", 32'(n + 6), 32'h7);
        end_access("rdy");

        // Unmapped access times out into bus error
        begin_access(24'hE00000);
        chk("um_cs_e0", 32'(cs_n), 32'hFFFF);
        wait_resp(n);
        chk("um_lat", 32'(n), 32'h8);
        chk("um_berr", 32'(bus.cpu_berr_n), 32'h0);
        chk("um_dtack", 32'(bus.cpu_dtack_n), 32'h1);
        chk("um_cs", 32'(cs_n), 32'hFFFF);
        end_access("um");

        // Savestate regions override a catch-all window 0
        set_win(0, 1'b1, 8'h00, 8'h00, 4'd2);
        ss_override = 1'b1;
        begin_access(24'h00007C);
        chk("ssv_sel", 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h5);
        chk("ssv_cs", 32'(cs_n), 32'hFFFF);
        wait_resp(n);
        chk("ssv_lat", 32'(n), 32'h1);
        end_access("ssv");
        begin_access(24'hFF0012);
        chk("sss_sel", 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h3);
        wait_resp(n);
        chk("sss_lat", 32'(n), 32'h1);
        end_access("sss");
        begin_access(24'h000005);
        chk("ssr_sel", 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h6);
        chk("ssr_cs", 32'(cs_n), 32'hFFFF);
        end_access("ssr");
        ss_override = 1'b0;
        begin_access(24'h00007C);
        chk("cat_cs", 32'(cs_n), 32'hFFFE);
        chk("cat_idx", 32'(hit_idx), 32'h0);
        chk("cat_ss", 32'({ss_save_n, ss_vec_n, ss_reset_n}), 32'h7);
        wait_resp(n);
        chk("cat_lat", 32'(n), 32'h3);
        end_access("cat");
        set_win(0, 1'b0, 8'h00, 8'h00, 4'd0);

        // Address strobe withdrawn during the wait-state countdown
        begin_access(24'h400000);
        chk("ab_cs", 32'(cs_n), 32'hFFEF);
        repeat (2) @(posedge clk);
        #1;
        chk("ab_dtack_mid", 32'(bus.cpu_dtack_n), 32'h1);
        end_access("ab");
        early = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.cpu_dtack_n !== 1'b1) early = 1'b1;
        end
        chk("ab_no_dtack", 32'(early), 32'h0);
        begin_access(24'h100000);
        chk("ab_next_cs", 32'(cs_n), 32'hFFFB);
        wait_resp(n);
        chk("ab_next_lat", 32'(n), 32'h1);
        end_access("ab_next");

        // Asynchronous reset in the middle of WAIT
        begin_access(24'h400000);
        @(posedge clk);
        #1;
        chk("rw_cs_pre", 32'(cs_n), 32'hFFEF);
        #2 reset_n = 1'b0;
        #1;
        chk("rw_cs", 32'(cs_n), 32'hFFFF);
        chk("rw_dtack", 32'(bus.cpu_dtack_n), 32'h1);
        chk("rw_berr", 32'(bus.cpu_berr_n), 32'h1);
        bus.cpu_as_n = 1'b1;
        bus.cpu_ds_n = 2'b11;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        begin_access(24'h100000);
        chk("rw_next_cs", 32'(cs_n), 32'hFFFB);
        chk("rw_next_idx", 32'(hit_idx), 32'h2);
        wait_resp(n);
        chk("rw_next_lat", 32'(n), 32'h1);
        end_access("rw_next");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
